// File: rtl/if_id_hazard_reg.sv
// -----------------------------------------------------------------------------
// if_id_hazard_reg
//
// IF/ID pipeline register with load-use hazard detection and control-transfer
// flush. The register captures the fetched instruction and its PC+4 on the
// falling clock edge, shared with the other pipeline registers. It holds its
// contents across a load-use stall and asks ID/EX for a bubble. On a taken
// branch or a jump it squashes the held instruction to NOP_INSTR.
//
// Parameters
//   NOP_INSTR       instruction word loaded on flush and reset
//
// Ports
//   clk             pipeline clock; registers update on its falling edge
//   reset           asynchronous, active-high reset
//   pc_plus4_in     PC+4 of the fetched instruction
//   instr_in        fetched instruction word
//   id_ex_mem_read  mem_read of the instruction now in EX
//   id_ex_rt        destination rt of the instruction now in EX
//   branch_taken    taken branch resolved downstream
//   jump_in_id      decode has identified a jump
//   nextpc_out      registered PC+4
//   instr_out       registered instruction
//   valid_out       held instruction is live (not a flushed bubble)
//   rs_out/rt_out/rd_out/imm_out  field slices of instr_out
//   pc_write_en     fetch PC may advance
//   bubble          ID/EX must load zeroed controls this edge
//   stall_cnt       number of hold edges (performance counter)
//   flush_cnt       number of flush edges (performance counter)
//
// Build option
//   IF_ID_PERF_CNT_EN  when defined, stall_cnt and flush_cnt are saturating
//                      16-bit counters. When undefined, both outputs are
//                      tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module if_id_hazard_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] instr_in,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic        branch_taken,
    input  logic        jump_in_id,
    output logic [31:0] nextpc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [15:0] imm_out,
    output logic        pc_write_en,
    output logic        bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    logic [31:0] instr_r;
    logic [31:0] nextpc_r;
    logic        valid_r;
    logic        hazard_s;
    logic        flush_s;
    logic        pc_write_en_s;
    logic        bubble_s;

    // A load writing $zero never produces a usable value, so it can never
    // be a hazard source.
    function automatic logic load_use_match(
        input logic [4:0] dst,
        input logic [4:0] src_rs,
        input logic [4:0] src_rt
    );
        return (dst != 5'd0) && ((dst == src_rs) || (dst == src_rt));
    endfunction

    // The field outputs are pure slices of the held word, so they stay
    // stable while the register holds.
    assign instr_out  = instr_r;
    assign nextpc_out = nextpc_r;
    assign valid_out  = valid_r;
    assign rs_out     = instr_r[25:21];
    assign rt_out     = instr_r[20:16];
    assign rd_out     = instr_r[15:11];
    assign imm_out    = instr_r[15:0];

    assign pc_write_en = pc_write_en_s;
    assign bubble      = bubble_s;

    // Hazard and flush decode. Flush takes priority: the stalled
    // instruction is being squashed anyway, so no bubble is needed and
    // fetch must redirect.
    always_comb begin
        hazard_s      = 1'b0;
        flush_s       = 1'b0;
        pc_write_en_s = 1'b1;
        bubble_s      = 1'b0;
        // A flushed slot (valid_r low) never stalls, even when its fields match.
        if (valid_r && id_ex_mem_read) begin
            hazard_s = load_use_match(id_ex_rt, instr_r[25:21], instr_r[20:16]);
        end else begin
            hazard_s = 1'b0;
        end
        flush_s = branch_taken || jump_in_id;
        if (flush_s) begin
            pc_write_en_s = 1'b1;
            bubble_s      = 1'b0;
        end else if (hazard_s) begin
            pc_write_en_s = 1'b0;
            bubble_s      = 1'b1;
        end else begin
            pc_write_en_s = 1'b1;
            bubble_s      = 1'b0;
        end
    end

    // IF/ID register. Priority on each edge is flush, then hold, then load.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            instr_r  <= NOP_INSTR;
            nextpc_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else if (flush_s) begin
            instr_r  <= NOP_INSTR;
            nextpc_r <= pc_plus4_in;
            valid_r  <= 1'b0;
        end else if (hazard_s) begin
            instr_r  <= instr_r;
            nextpc_r <= nextpc_r;
            valid_r  <= valid_r;
        end else begin
            instr_r  <= instr_in;
            nextpc_r <= pc_plus4_in;
            valid_r  <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating performance counters. They count hold edges and flush edges.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else if (flush_s) begin
            stall_cnt_r <= stall_cnt_r;
            if (flush_cnt_r != 16'hFFFF) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end else if (hazard_s) begin
            flush_cnt_r <= flush_cnt_r;
            if (stall_cnt_r != 16'hFFFF) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            stall_cnt_r <= stall_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// -----------------------------------------------------------------------------
// Testbench for if_id_hazard_reg. Directed steps are followed by randomized
// cycles. The expected values come from a behavioural model of the pipeline
// slot that is written from the register's rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_if_id_hazard_reg;

    logic        clk;
    logic        reset;
    logic [31:0] pc_plus4_in;
    logic [31:0] instr_in;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        branch_taken;
    logic        jump_in_id;
    logic [31:0] nextpc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic [15:0] imm_out;
    logic        pc_write_en;
    logic        bubble;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_stall;
    int          m_flush;

    localparam logic [31:0] NOP = 32'h0000_0000;

    if_id_hazard_reg #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_plus4_in(pc_plus4_in), .instr_in(instr_in),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .branch_taken(branch_taken), .jump_in_id(jump_in_id),
        .nextpc_out(nextpc_out), .instr_out(instr_out), .valid_out(valid_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .imm_out(imm_out),
        .pc_write_en(pc_write_en), .bubble(bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] w, input int lsb, input int nbits);
        return (w >> lsb) % (32'd1 << nbits);
    endfunction

    function automatic logic model_hazard();
        logic [31:0] rs;
        logic [31:0] rt;
        rs = fld(m_instr, 21, 5);
        rt = fld(m_instr, 16, 5);
        return m_valid && id_ex_mem_read && (id_ex_rt != 5'd0) &&
               ((32'(id_ex_rt) == rs) || (32'(id_ex_rt) == rt));
    endfunction

    task automatic model_reset();
        m_instr = NOP;
        m_pc    = 32'h0000_0000;
        m_valid = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic check_regs(input string tag);
        int es;
        int ef;
`ifdef IF_ID_PERF_CNT_EN
        es = m_stall;
        ef = m_flush;
`else
        es = 0;
        ef = 0;
`endif
        check({tag, ".instr"}, instr_out, m_instr);
        check({tag, ".pc"}, nextpc_out, m_pc);
        check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
        check({tag, ".rs"}, 32'(rs_out), fld(m_instr, 21, 5));
        check({tag, ".rt"}, 32'(rt_out), fld(m_instr, 16, 5));
        check({tag, ".rd"}, 32'(rd_out), fld(m_instr, 11, 5));
        check({tag, ".imm"}, 32'(imm_out), fld(m_instr, 0, 16));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(es));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(ef));
    endtask

    // One pipeline cycle: drive after the rising edge, check the stall
    // controls, let the falling edge update, then check the registers.
    task automatic cycle(input string tag, input logic mr, input logic [4:0] ert,
                         input logic br, input logic jmp,
                         input logic [31:0] pc, input logic [31:0] ins);
        logic h;
        logic f;
        @(posedge clk);
        #1;
        id_ex_mem_read = mr;
        id_ex_rt       = ert;
        branch_taken   = br;
        jump_in_id     = jmp;
        pc_plus4_in    = pc;
        instr_in       = ins;
        #1;
        h = model_hazard();
        f = br || jmp;
        check({tag, ".pc_write_en"}, 32'(pc_write_en), 32'(!h || f));
        check({tag, ".bubble"}, 32'(bubble), 32'(h && !f));
        @(negedge clk);
        #1;
        if (f) begin
            m_instr = NOP;
            m_valid = 1'b0;
            m_pc    = pc;
            if (m_flush < 65535) m_flush++;
        end else if (h) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_instr = ins;
            m_pc    = pc;
            m_valid = 1'b1;
        end
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [4:0]  ert;
        reset = 1'b1;
        pc_plus4_in = 32'h0; instr_in = 32'h0; id_ex_mem_read = 1'b0;
        id_ex_rt = 5'd0; branch_taken = 1'b0; jump_in_id = 1'b0;
        model_reset();
        #2;
        check_regs("reset");
        check("reset.pc_write_en", 32'(pc_write_en), 32'h1);
        check("reset.bubble", 32'(bubble), 32'h0);

        // Release reset between falling edges; the first edge loads normally.
        @(negedge clk);
        #2 reset = 1'b0;
        cycle("first_load", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0004, 32'h8C22_0004);

        // Asynchronous reset in mid-cycle
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_regs("mid_reset");
        check("mid_reset.pc_write_en", 32'(pc_write_en), 32'h1);
        #1 reset = 1'b0;

        // Load-use stall for one cycle, then the load proceeds
        cycle("lu_load", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0008, 32'h0043_2020);
        cycle("lu_hold", 1'b1, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 32'h0064_2822);
        cycle("lu_next", 1'b0, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 32'h0064_2822);

        // Load into $zero: no hazard
        cycle("zero_load", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0010, 32'h0043_2020);
        cycle("zero_rt", 1'b1, 5'd0, 1'b0, 1'b0, 32'h0000_0014, 32'h1234_5678);

        // Hazard and branch together: flush wins
        cycle("hb_load", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0018, 32'h0043_2020);
        cycle("hb_flush", 1'b1, 5'd3, 1'b1, 1'b0, 32'h0000_001C, 32'hDEAD_BEEF);

        // Jump flush
        cycle("jmp_load", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0020, 32'h0043_2020);
        cycle("jmp_flush", 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            case ($urandom_range(0, 3))
                0:       ert = 5'(fld(m_instr, 21, 5));
                1:       ert = 5'(fld(m_instr, 16, 5));
                default: ert = 5'($urandom_range(0, 31));
            endcase
            cycle("rand", 1'($urandom_range(0, 1)), ert,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  $urandom, rnd);
        end

`ifdef IF_ID_PERF_CNT_EN
        // Forced stall for 65540 edges: the stall counter saturates.
        cycle("sat_load", 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0100, 32'h00A0_0000);
        @(posedge clk);
        #1;
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd5;
        branch_taken   = 1'b0;
        jump_in_id     = 1'b0;
        instr_in       = 32'h1111_1111;
        pc_plus4_in    = 32'h0000_0104;
        for (int n = 0; n < 65540; n++) begin
            @(negedge clk);
            if (m_stall < 65535) m_stall++;
        end
        #1;
        check("sat.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        check_regs("sat");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
